// File: rtl/morph_filter.sv
// 3x3 binary erode/dilate engine: streams a mask frame from a source BRAM and writes
// the interior result pixels to a destination BRAM, one window column per fetch.
module morph_filter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2,
    parameter int FG_VAL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_we
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [2:0]        K_CAP0 = 3'(RD_LAT);
    localparam logic [2:0]        K_CAP1 = 3'(RD_LAT + 1);
    localparam logic [2:0]        K_LAST = 3'(RD_LAT + 2);
    localparam logic [CW-1:0]     C_LAST = CW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 2);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        k_p0;
    logic [CW-1:0]     c_p0;
    logic [YW-1:0]     y_p0;
    logic [ADDR_W-1:0] base_m;
    logic              mode_r;
    logic [1:0]        col_cap_p0;
    logic [2:0]        col1_p1, col2_p1;
    logic              fg;
    logic [2:0]        col_in;

    function automatic logic [PIX_W-1:0] morph_result(input logic [8:0] win, input logic dil);
        logic hit;
        hit = dil ? (|win) : (&win);
        return hit ? PIX_W'(FG_VAL) : '0;
    endfunction

    assign fg     = |src_data;
    assign col_in = {fg, col_cap_p0[1], col_cap_p0[0]};
    assign busy   = (state == FETCH) || (state == WRITE);
    assign done   = (state == DONE);
    assign dst_we = (state == WRITE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (k_p0 == K_LAST && c_p0 >= CW'(2)) state_nxt = WRITE;
            WRITE: if (c_p0 == C_LAST && y_p0 == Y_LAST) state_nxt = DONE;
                   else                                  state_nxt = FETCH;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // base_m tracks the address of row y-1; rows y and y+1 are reached by +WIDTH steps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_p0     <= '0;
            c_p0     <= '0;
            y_p0     <= '0;
            base_m   <= '0;
            mode_r   <= 1'b0;
            src_addr <= '0;
            dst_addr <= '0;
            dst_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_r   <= mode;
                    y_p0     <= YW'(1);
                    c_p0     <= '0;
                    k_p0     <= '0;
                    base_m   <= '0;
                    src_addr <= '0;
                end
                FETCH: begin
                    if (k_p0 != K_LAST) begin
                        k_p0 <= k_p0 + 3'd1;
                        if (k_p0 < 3'd2) src_addr <= src_addr + W_A;
                    end else if (c_p0 < CW'(2)) begin
                        c_p0     <= c_p0 + CW'(1);
                        k_p0     <= '0;
                        src_addr <= base_m + ADDR_W'(c_p0) + ADDR_W'(1);
                    end else begin
                        dst_addr <= base_m + W_A + ADDR_W'(c_p0) - ADDR_W'(1);
                        dst_data <= morph_result({col1_p1, col2_p1, col_in}, mode_r);
                    end
                end
                WRITE: begin
                    k_p0 <= '0;
                    if (c_p0 != C_LAST) begin
                        c_p0     <= c_p0 + CW'(1);
                        src_addr <= base_m + ADDR_W'(c_p0) + ADDR_W'(1);
                    end else if (y_p0 != Y_LAST) begin
                        y_p0     <= y_p0 + YW'(1);
                        c_p0     <= '0;
                        base_m   <= base_m + W_A;
                        src_addr <= base_m + W_A;
                    end
                end
                default: ;
            endcase
        end
    end

    // capture stage: row r of the column returns at fetch cycle RD_LAT+r
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            if (k_p0 == K_CAP0) col_cap_p0[0] <= fg;
            if (k_p0 == K_CAP1) col_cap_p0[1] <= fg;
            if (k_p0 == K_LAST) begin
                col1_p1 <= col2_p1;
                col2_p1 <= col_in;
            end
        end
    end

endmodule

// File: tb/tb_morph_filter.sv
// Bench for morph_filter: three instances (RD_LAT 1, 2, 4) share one source frame;
// the RD_LAT=2 instance is scoreboarded write by write, the others by final contents.
module tb_morph_filter;
    localparam int W = 8, H = 6, PW = 4, AW = 19, FG = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic [2:0] busy, done, we;
    logic [2:0][AW-1:0] sa, da;
    logic [2:0][PW-1:0] sd, dd;
    logic clr = 1'b0;

    logic [PW-1:0] src_mem [64];
    logic [PW-1:0] dst_mem [3][64];
    logic [PW-1:0] p1;
    logic [PW-1:0] p2 [2];
    logic [PW-1:0] p4 [4];

    always #5 clk = ~clk;

    morph_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(1), .FG_VAL(FG)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy[0]), .done(done[0]),
        .src_addr(sa[0]), .src_data(sd[0]), .dst_addr(da[0]), .dst_data(dd[0]), .dst_we(we[0]));
    morph_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(2), .FG_VAL(FG)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy[1]), .done(done[1]),
        .src_addr(sa[1]), .src_data(sd[1]), .dst_addr(da[1]), .dst_data(dd[1]), .dst_we(we[1]));
    morph_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(4), .FG_VAL(FG)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy[2]), .done(done[2]),
        .src_addr(sa[2]), .src_data(sd[2]), .dst_addr(da[2]), .dst_data(dd[2]), .dst_we(we[2]));

    // source BRAM read pipelines of depth 1, 2 and 4
    always @(posedge clk) begin
        p1    <= src_mem[sa[0][5:0]];
        p2[0] <= src_mem[sa[1][5:0]];
        p2[1] <= p2[0];
        p4[0] <= src_mem[sa[2][5:0]];
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign sd[0] = p1;
    assign sd[1] = p2[1];
    assign sd[2] = p4[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                for (int j = 0; j < 64; j++) dst_mem[i][j] <= 4'hF;
            end else if (we[i]) begin
                dst_mem[i][da[i][5:0]] <= dd[i];
            end
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [PW-1:0] d;
    } wr_t;
    typedef struct {
        int   pat;
        logic md;
        int   exp_fg;
    } vec_t;

    wr_t  q[$];
    vec_t tbl[6];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_wr = 0, n_fg = 0;
    int done_cnt[3];
    int done_cyc[3];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one negedge step with the write scoreboard and done bookkeeping
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (we[1]) begin
            n_wr++;
            if (dd[1] == PW'(FG)) n_fg++;
            if (q.size() == 0) begin
                chk("unexpected_write_addr", int'(da[1]), -1);
            end else begin
                e = q.pop_front();
                chk("wr_addr", int'(da[1]), int'(e.a));
                chk("wr_data", int'(dd[1]), int'(e.d));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    endtask

    task automatic load_src(input int pat);
        for (int i = 0; i < 64; i++) begin
            if (i >= W * H)    src_mem[i] = '0;
            else if (pat == 0) src_mem[i] = PW'((i % 15) + 1);
            else if (pat == 1) src_mem[i] = (i == 28) ? PW'(5) : PW'(0);
            else if (pat == 2) src_mem[i] = (i == 28) ? PW'(0) : PW'((i % 15) + 1);
            else               src_mem[i] = '0;
        end
    endtask

    task automatic build_expect(input logic md);
        wr_t e;
        logic all1, any1;
        q.delete();
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                all1 = 1'b1;
                any1 = 1'b0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (src_mem[(y + dy) * W + x + dx] != 0) any1 = 1'b1;
                        else                                      all1 = 1'b0;
                    end
                e.a = AW'(y * W + x);
                e.d = (md ? any1 : all1) ? PW'(FG) : PW'(0);
                q.push_back(e);
            end
        end
    endtask

    function automatic int pass_cycles(input int rl);
        return (H - 2) * (3 * (rl + 3) + (W - 3) * (rl + 4) + 1) + 1;
    endfunction

    task automatic run(input int pat, input logic md, input int exp_fg, input bit mid_pulse);
        int t0, bad_border, diff0, diff2, lat[3];
        bit all_done;
        lat[0] = 1; lat[1] = 2; lat[2] = 4;
        load_src(pat);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        build_expect(md);
        n_wr = 0;
        n_fg = 0;
        for (int i = 0; i < 3; i++) begin done_cnt[i] = 0; done_cyc[i] = 0; end
        mode  = md;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 7);
        all_done = 1'b0;
        for (int k = 0; k < 2000 && !all_done; k++) begin
            if (mid_pulse && k == 60) begin
                start = 1'b1;
                mode  = ~md;
            end
            tick();
            start = 1'b0;
            all_done = (done_cnt[0] > 0) && (done_cnt[1] > 0) && (done_cnt[2] > 0);
        end
        chk("pass_completed", int'(all_done), 1);
        for (int k = 0; k < 6; k++) tick();
        mode = 1'b0;
        chk("write_count", n_wr, (W - 2) * (H - 2));
        chk("fg_count", n_fg, exp_fg);
        chk("pending_writes", q.size(), 0);
        chk("busy_after_done", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("done_pulses_rl%0d", lat[i]), done_cnt[i], 1);
            chk($sformatf("latency_rl%0d", lat[i]), done_cyc[i] - t0, pass_cycles(lat[i]));
        end
        bad_border = 0; diff0 = 0; diff2 = 0;
        for (int a = 0; a < W * H; a++) begin
            if ((a % W == 0 || a % W == W - 1 || a / W == 0 || a / W == H - 1) && dst_mem[1][a] != 4'hF)
                bad_border++;
            if (dst_mem[0][a] != dst_mem[1][a]) diff0++;
            if (dst_mem[2][a] != dst_mem[1][a]) diff2++;
        end
        chk("border_untouched", bad_border, 0);
        chk("dst_match_rl1", diff0, 0);
        chk("dst_match_rl4", diff2, 0);
    endtask

    initial begin
        int quiet_we, quiet_done;
        tbl[0] = '{pat: 0, md: 1'b0, exp_fg: 24};
        tbl[1] = '{pat: 1, md: 1'b1, exp_fg: 9};
        tbl[2] = '{pat: 1, md: 1'b0, exp_fg: 0};
        tbl[3] = '{pat: 2, md: 1'b0, exp_fg: 15};
        tbl[4] = '{pat: 0, md: 1'b1, exp_fg: 24};
        tbl[5] = '{pat: 3, md: 1'b1, exp_fg: 0};
        load_src(0);

        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_src_addr", int'(sa[1]), 0);
        chk("reset_dst_addr", int'(da[1]), 0);
        chk("reset_dst_data", int'(dd[1]), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) run(tbl[v].pat, tbl[v].md, tbl[v].exp_fg, 1'b0);

        // start re-pulsed and mode flipped mid-pass: erode latched at the first start holds
        run(2, 1'b0, 15, 1'b1);

        // reset in the middle of line 2, then a clean pass
        load_src(0);
        build_expect(1'b0);
        n_wr = 0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2000 && n_wr < 8; k++) tick();
        chk("reached_line2", n_wr, 8);
        q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_we", int'(we), 0);
        chk("midreset_dst_addr", int'(da[1]), 0);
        chk("midreset_src_addr", int'(sa[1]), 0);
        quiet_we = 0;
        quiet_done = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (we != 3'b000) quiet_we++;
            if (done != 3'b000 || busy != 3'b000) quiet_done++;
        end
        chk("after_reset_writes", quiet_we, 0);
        chk("after_reset_done_busy", quiet_done, 0);
        run(0, 1'b0, 24, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
